// File: rtl/swim_pkg.sv
// Shared types and constants for the SWIM-style open-drain sequence transmitter.
package swim_pkg;

  typedef enum logic {
    IDLE = 1'b0,
    SEND = 1'b1
  } swim_state_e;

  // Entry burst sent MSB first: four 1 kHz pulses, four 2 kHz pulses, then release.
  localparam int SWIM_ENTRY_LEN = 45;
  localparam logic [SWIM_ENTRY_LEN-1:0] SWIM_ENTRY_SEQ =
    {16'b0011_0011_0011_0011, 8'b0101_0101, 21'h1F_FFFF};

  // 0.25 ms bit period at 48 MHz; the short value keeps simulations fast.
  localparam int CLK_COUNT_SYN = 12000;
  localparam int CLK_COUNT_SIM = 4;

endpackage

// File: rtl/swim_bit_timer.sv
// Bit-period divider: tick is high on the last clk cycle of each CLK_COUNT-cycle period.
module swim_bit_timer #(
  parameter int CLK_COUNT = 12000
) (
  input  logic clk,
  input  logic rst,
  input  logic clr,
  input  logic en,
  output logic tick
);

  localparam int CW = (CLK_COUNT > 1) ? $clog2(CLK_COUNT) : 1;
  localparam logic [CW-1:0] LAST = CW'(CLK_COUNT - 1);

  logic [CW-1:0] cnt;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt <= '0;
    end else if (clr) begin
      cnt <= '0;
    end else if (en) begin
      cnt <= (cnt == LAST) ? '0 : cnt + 1'b1;
    end
  end

  assign tick = en && (cnt == LAST);

endmodule

// File: rtl/swim_seq_tx.sv
// Open-drain serial sequence transmitter with per-bit line readback and abort.
module swim_seq_tx
  import swim_pkg::*;
#(
  parameter int PAT_W     = SWIM_ENTRY_LEN,
  parameter int CH        = 3,
  parameter int CLK_COUNT = CLK_COUNT_SYN,
  parameter int LEN_W     = $clog2(PAT_W + 1)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             abort,
  input  logic [PAT_W-1:0] pattern,
  input  logic [LEN_W-1:0] len,
  input  logic [CH-1:0]    ch_mask,
  input  logic [CH-1:0]    line_in,
  output logic [CH-1:0]    drive_low,
  output logic             busy,
  output logic             done,
  output logic [PAT_W-1:0] rx_data
);

  localparam int IDX_W = (PAT_W > 1) ? $clog2(PAT_W) : 1;
  localparam logic [LEN_W-1:0] MAX_LEN = LEN_W'(PAT_W);

  swim_state_e      state;
  logic [PAT_W-1:0] pattern_q;
  logic [CH-1:0]    mask_q;
  logic [CH-1:0]    sync1;
  logic [CH-1:0]    sync2;
  logic [IDX_W-1:0] idx;
  logic [LEN_W-1:0] eff_len;
  logic [IDX_W-1:0] first_idx;
  logic [IDX_W-1:0] next_idx;
  logic             accept;
  logic             sample;
  logic             tick;

  always_comb begin
    eff_len   = (len > MAX_LEN) ? MAX_LEN : len;
    first_idx = IDX_W'(eff_len - 1'b1);
    next_idx  = idx - 1'b1;
    accept    = (state == IDLE) && start && (len != '0);
    // Unmasked channels read as released so an empty mask samples 1.
    sample    = &(sync2 | ~mask_q);
  end

  // Pad inputs idle high (pulled up), so the synchronisers reset to 1.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync1 <= '1;
      sync2 <= '1;
    end else begin
      sync1 <= line_in;
      sync2 <= sync1;
    end
  end

  swim_bit_timer #(
    .CLK_COUNT(CLK_COUNT)
  ) u_bit_timer (
    .clk (clk),
    .rst (rst),
    .clr (accept),
    .en  (state == SEND),
    .tick(tick)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= IDLE;
      pattern_q <= '0;
      mask_q    <= '0;
      idx       <= '0;
      drive_low <= '0;
      busy      <= 1'b0;
      done      <= 1'b0;
      rx_data   <= '0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          if (accept) begin
            state     <= SEND;
            pattern_q <= pattern;
            mask_q    <= ch_mask;
            idx       <= first_idx;
            rx_data   <= '0;
            busy      <= 1'b1;
            drive_low <= ch_mask & {CH{~pattern[first_idx]}};
          end
        end
        SEND: begin
          // Abort wins over a bit boundary in the same cycle; rx_data keeps what it has.
          if (abort) begin
            state     <= IDLE;
            busy      <= 1'b0;
            drive_low <= '0;
          end else if (tick) begin
            rx_data <= {rx_data[PAT_W-2:0], sample};
            if (idx == '0) begin
              state     <= IDLE;
              busy      <= 1'b0;
              drive_low <= '0;
              done      <= 1'b1;
            end else begin
              idx       <= next_idx;
              drive_low <= mask_q & {CH{~pattern_q[next_idx]}};
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_swim_seq_tx.sv
// Scoreboard bench for swim_seq_tx with an ideal pull-up line model.
module tb_swim_seq_tx;

  localparam int PW   = 8;
  localparam int NC   = 3;
  localparam int CLKC = 4;
  localparam int LW   = 4;

  logic          clk = 1'b0;
  logic          rst;
  logic          start;
  logic          abort;
  logic [PW-1:0] pattern;
  logic [LW-1:0] len;
  logic [NC-1:0] ch_mask;
  logic [NC-1:0] line_in;
  logic [NC-1:0] force_low;
  logic [NC-1:0] drive_low;
  logic          busy;
  logic          done;
  logic [PW-1:0] rx_data;

  int checks   = 0;
  int failures = 0;

  logic [NC-1:0] drv_q[$];
  logic [PW-1:0] rx_q[$];
  int            cyc_q[$];
  int            cur_abort_at = -1;

  always #5 clk = ~clk;

  assign line_in = ~drive_low & ~force_low;

  swim_seq_tx #(
    .PAT_W    (PW),
    .CH       (NC),
    .CLK_COUNT(CLKC),
    .LEN_W    (LW)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .start    (start),
    .abort    (abort),
    .pattern  (pattern),
    .len      (len),
    .ch_mask  (ch_mask),
    .line_in  (line_in),
    .drive_low(drive_low),
    .busy     (busy),
    .done     (done),
    .rx_data  (rx_data)
  );

  // Called at a negedge; pushes expectations and pulses start for one cycle.
  task automatic issue(input logic [PW-1:0] pat, input int len_req, input logic [NC-1:0] mask,
                       input logic [NC-1:0] frc, input int abort_at);
    int            eff;
    int            nb;
    logic [NC-1:0] drv;
    logic [PW-1:0] r;
    logic          s;
    eff = (len_req > PW) ? PW : len_req;
    nb  = (abort_at > 0) ? abort_at / CLKC : eff;
    r   = '0;
    for (int k = 0; k < eff; k++) begin
      drv = mask & {NC{~pat[eff-1-k]}};
      drv_q.push_back(drv);
      s = &((~drv & ~frc) | ~mask);
      if (k < nb) r = {r[PW-2:0], s};
    end
    if (eff > 0) begin
      rx_q.push_back(r);
      cyc_q.push_back((abort_at > 0) ? abort_at : eff * CLKC);
    end
    cur_abort_at = abort_at;
    force_low    = frc;
    pattern      = pat;
    len          = LW'(len_req);
    ch_mask      = mask;
    start        = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask

  // Follows one sequence from its first busy cycle; returns at the negedge where busy fell.
  task automatic monitor(input int restart_at, input string nm);
    int            cyc;
    int            exp_cyc;
    logic [NC-1:0] cur;
    logic [PW-1:0] exp_rx;
    cyc     = 0;
    cur     = '0;
    exp_rx  = (rx_q.size() > 0) ? rx_q.pop_front() : '0;
    exp_cyc = (cyc_q.size() > 0) ? cyc_q.pop_front() : 0;
    while (busy === 1'b1 && cyc < 400) begin
      cyc++;
      if ((cyc - 1) % CLKC == 0) cur = (drv_q.size() > 0) ? drv_q.pop_front() : '0;
      checks++;
      if (drive_low !== cur) begin
        failures++;
        $display("FAIL %s drive cyc=%0d got=%b exp=%b", nm, cyc, drive_low, cur);
      end
      if (cyc == restart_at) begin
        start   = 1'b1;
        pattern = ~pattern;
        len     = LW'(4);
        ch_mask = 3'b001;
      end else begin
        start = 1'b0;
      end
      abort = (cyc == cur_abort_at);
      @(negedge clk);
    end
    start = 1'b0;
    abort = 1'b0;
    checks++;
    if (cyc != exp_cyc) begin
      failures++;
      $display("FAIL %s busy_cycles got=%0d exp=%0d", nm, cyc, exp_cyc);
    end
    checks++;
    if (done !== (cur_abort_at < 0)) begin
      failures++;
      $display("FAIL %s done_at_end got=%b exp=%b", nm, done, (cur_abort_at < 0));
    end
    checks++;
    if (drive_low !== '0) begin
      failures++;
      $display("FAIL %s release got=%b exp=000", nm, drive_low);
    end
    checks++;
    if (rx_data !== exp_rx) begin
      failures++;
      $display("FAIL %s rx_data got=%b exp=%b", nm, rx_data, exp_rx);
    end
    drv_q.delete();
    cur_abort_at = -1;
  endtask

  task automatic idle_check(input int n, input string nm);
    repeat (n) begin
      @(negedge clk);
      checks++;
      if (busy !== 1'b0 || done !== 1'b0 || drive_low !== '0) begin
        failures++;
        $display("FAIL %s idle busy=%b done=%b drive=%b exp 0/0/000", nm, busy, done, drive_low);
      end
    end
  endtask

  task automatic test_reset;
    #1;
    checks++;
    if (busy !== 1'b0 || done !== 1'b0 || drive_low !== '0 || rx_data !== '0) begin
      failures++;
      $display("FAIL reset_state busy=%b done=%b drive=%b rx=%b exp all 0", busy, done, drive_low, rx_data);
    end
    repeat (3) @(negedge clk);
    rst = 1'b0;
    idle_check(3, "post_reset");
  endtask

  task automatic test_basic;
    issue(8'b1010_0110, 8, 3'b111, 3'b000, -1);
    monitor(-1, "basic");
    idle_check(2, "basic_tail");
  endtask

  task automatic test_single_ch;
    issue(8'b0110_1101, 3, 3'b010, 3'b000, -1);
    monitor(-1, "single_ch");
    idle_check(2, "single_ch_tail");
  endtask

  task automatic test_abort;
    issue(8'b1010_0110, 8, 3'b111, 3'b000, 10);
    monitor(-1, "abort");
    idle_check(2, "abort_tail");
    abort = 1'b1;
    issue(8'b1100_0011, 8, 3'b110, 3'b000, -1);
    abort = 1'b0;
    monitor(-1, "after_abort");
    idle_check(2, "after_abort_tail");
  endtask

  task automatic test_len_edge;
    issue(8'b1010_0110, 0, 3'b111, 3'b000, -1);
    idle_check(4, "len_zero");
    issue(8'b1001_0110, 12, 3'b111, 3'b000, -1);
    monitor(-1, "len_clamp");
    idle_check(2, "len_clamp_tail");
  endtask

  task automatic test_back_to_back;
    issue(8'b0011_1100, 8, 3'b111, 3'b000, -1);
    monitor(6, "restart_ignored");
    issue(8'b0101_1010, 5, 3'b101, 3'b000, -1);
    monitor(-1, "start_on_done");
    idle_check(3, "b2b_tail");
  endtask

  task automatic test_force;
    issue(8'b1100_1011, 8, 3'b001, 3'b001, -1);
    monitor(-1, "forced_low");
    force_low = '0;
    idle_check(2, "forced_tail");
  endtask

  task automatic test_async_reset;
    issue(8'b1010_0110, 8, 3'b111, 3'b000, -1);
    repeat (5) @(negedge clk);
    checks++;
    if (busy !== 1'b1 || drive_low !== 3'b111 || rx_data !== 8'h01) begin
      failures++;
      $display("FAIL pre_reset busy=%b drive=%b rx=%b exp 1/111/00000001", busy, drive_low, rx_data);
    end
    #2 rst = 1'b1;
    #1;
    checks++;
    if (busy !== 1'b0 || drive_low !== '0 || rx_data !== '0 || done !== 1'b0) begin
      failures++;
      $display("FAIL async_reset busy=%b drive=%b rx=%b done=%b exp 0", busy, drive_low, rx_data, done);
    end
    drv_q.delete();
    rx_q.delete();
    cyc_q.delete();
    #20 rst = 1'b0;
    @(negedge clk);
    idle_check(4, "after_async_reset");
  endtask

  initial begin
    rst       = 1'b1;
    start     = 1'b0;
    abort     = 1'b0;
    pattern   = '0;
    len       = '0;
    ch_mask   = '0;
    force_low = '0;
    test_reset;
    test_basic;
    test_single_ch;
    test_abort;
    test_len_edge;
    test_back_to_back;
    test_force;
    test_async_reset;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/swim_seq_tx.md
Name: swim_seq_tx

Overview:
Parametrised open-drain serial sequence transmitter for SWIM-style debug lines. It generalises the fixed-pattern SWIM entry generator in several ways: a runtime-loadable pattern and length, a per-channel enable mask, and a compile-time bit period. It also adds per-bit readback of the line level and an abort input. It sits between the USB-UART command logic and the tristate pad buffers, and drives only the output-enable of pads whose data input is tied low.

Parameters:
PAT_W, 45, maximum pattern length in bits
CH, 3, number of open-drain output channels
CLK_COUNT, 12000, clk cycles per bit period (>=2)
LEN_W, $clog2(PAT_W+1), width of the len port

Ports:
clk  in  1  system clock (48 MHz)
rst  in  1  asynchronous, active-high reset
start  in  1  one-cycle request to begin a sequence
abort  in  1  terminates an active sequence
pattern  in  PAT_W  bits to send; pattern[len-1] goes first, pattern[0] goes last
len  in  LEN_W  number of bits to send
ch_mask  in  CH  channels that participate in this sequence
line_in  in  CH  raw pad input levels (asynchronous)
drive_low  out  CH  pad output enable; 1 = pull line low
busy  out  1  sequence in progress
done  out  1  one-cycle pulse on normal completion
rx_data  out  PAT_W  sampled line levels, one per bit sent; LSB = last bit sent

Behaviour:
- Reset (async, immediate): state IDLE; drive_low=0, busy=0, done=0, rx_data=0, tick counter=0, bit index=0. Line synchronisers are cleared to 1 (released level).
- States: IDLE, SEND.
- IDLE -> SEND: when start=1 and len!=0 at edge T.
  - Latch pattern, ch_mask and eff_len. eff_len = min(len, PAT_W).
  - Clear rx_data; load bit index = eff_len-1; clear tick counter.
  - From T+1: busy=1 and the first bit is on the line.
- start with len=0: ignored; no busy, no done.
- start while busy: ignored; latched values are unchanged.
- Pad drive: drive_low[i] = busy & mask_q[i] & ~pattern_q[idx]. Registered, so it changes on the same edge as busy/idx. Unmasked channels are never driven.
- Bit timing: each bit lasts exactly CLK_COUNT cycles. The tick counter counts 0..CLK_COUNT-1 and the bit advances when the counter wraps.
- Readback: line_in passes through a 2-flop synchroniser per channel. On the last cycle of each bit period, sample = AND of synced line_in over the masked channels (1 if mask_q==0), and rx_data <= {rx_data[PAT_W-2:0], sample}.
  - Because of the 2-cycle sync delay, the sample reflects the level from about cycle CLK_COUNT-3 of the bit period.
- Completion: at the end of the bit with idx==0, go to IDLE.
  - busy=0 and drive_low=0 on the next edge.
  - done=1 for exactly that one cycle. Total busy time is eff_len*CLK_COUNT cycles.
- Abort: abort=1 in SEND returns to IDLE on the next edge.
  - Lines are released, no done pulse, rx_data holds its partial contents.
  - abort has priority over bit-period completion in the same cycle. abort in IDLE has no effect.
- start and abort together in IDLE: start wins; abort is only evaluated in SEND.
- A new start is accepted in the same cycle that done=1 (state is already IDLE).
- No combinational path from any input to any output.

Decomposition:
- Package swim_pkg holds:
  - state enum {IDLE, SEND};
  - SWIM_ENTRY_SEQ, the 45-bit SWIM entry pattern constant, with SWIM_ENTRY_LEN;
  - default CLK_COUNT constants for synthesis (12000) and simulation (small).
- One natural sub-module: swim_bit_timer. It is a CLK_COUNT divider with synchronous clear (asserted on start) and async reset, and outputs a one-cycle tick on the last cycle of each period.
- Synchronisers, shift logic and the FSM stay in swim_seq_tx.
- SB_IO pad instances remain in the wrapper, not in this block.

Test Plan (CLK_COUNT=4, PAT_W=8, CH=3):
1. pattern=8'b1010_0110, len=8, mask=3'b111, line_in=~drive_low (ideal pull-up) -> busy for 32 cycles from T+1; drive_low on all channels follows 0,1,0,1,1,0,0,1 (1 = low), 4 cycles each; done pulses once at T+33; rx_data=8'b1010_0110.
2. len=3, pattern=8'bxxxx_x101, mask=3'b010 -> only drive_low[1] ever toggles, sequence 0,1,0; busy for 12 cycles; rx_data[2:0]=3'b101.
3. Abort at the 10th busy cycle -> drive_low=0 and busy=0 on the next edge; done never asserts; a second start, issued 2 cycles later, runs to completion normally.
4. start with len=0 -> busy stays 0 and there is no done. Then start with len=12 (> PAT_W) -> busy for exactly 32 cycles (clamped to 8 bits).
5. Assert start again mid-sequence with a different pattern -> no effect; output matches the original pattern. start coincident with done -> new sequence begins with busy high on the next cycle.
6. Async rst asserted mid-bit, between clock edges -> drive_low, busy and rx_data go to 0 immediately, without waiting for a clk edge. After release, idle with no spurious done. Also line_in[0] forced 0 during a '1' bit with mask=3'b001 -> the corresponding rx_data bit reads 0.
